twiddle_mult_seq: RTL and testbench

//  Consumer-side counterpart of the 128-point twiddle ROM (twiddlefactors_128) in the radix-2 DIT FFT.

---
 rtl/fft_pkg.sv | 37 +++
 rtl/twiddle_mult_seq_cmul.sv | 46 ++++
 rtl/twiddlefactors_128.sv | 37 +++
 rtl/twiddle_mult_seq.sv | 126 ++++++++++++
 tb/tb_twiddle_mult_seq.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, the packed twiddle word format and the per-stage twiddle address rule.
package fft_pkg;

  localparam int FFT_N     = 128;
  localparam int FFT_LOG2N = 7;
  localparam int TW_W      = 8;
  localparam int TW_FRAC   = 6;
  localparam int TW_ADDR_W = 6;

  localparam logic [2:0]           LAST_STAGE = 3'(FFT_LOG2N - 1);
  localparam logic [TW_ADDR_W-1:0] J_LAST     = TW_ADDR_W'(FFT_N / 2 - 1);

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;

  function automatic logic [2*TW_W-1:0] tw_pack(input tw_t w);
    return {w.re, w.im};
  endfunction

  function automatic tw_t tw_unpack(input logic [2*TW_W-1:0] p);
    tw_t w;
    w.re = p[2*TW_W-1:TW_W];
    w.im = p[TW_W-1:0];
    return w;
  endfunction

  // k = (j mod 2^s) * 2^(6-s); at s=6 the mask wraps to all ones.
  function automatic logic [TW_ADDR_W-1:0] tw_addr(input logic [2:0] s,
                                                   input logic [TW_ADDR_W-1:0] j);
    logic [TW_ADDR_W-1:0] mask;
    mask = (TW_ADDR_W'(1) << s) - TW_ADDR_W'(1);
    return (j & mask) << (3'd6 - s);
  endfunction

endpackage

// File: rtl/twiddle_mult_seq_cmul.sv
// Combinational complex multiply x*W (or x*conj(W)) with Q1.6 twiddle, optional rounding, saturation.
module cmul_q6
  import fft_pkg::*;
#(
  parameter int DW     = 16,
  parameter int RND_EN = 1
) (
  input  logic signed [DW-1:0]   xr_i,
  input  logic signed [DW-1:0]   xi_i,
  input  logic signed [TW_W-1:0] wr_i,
  input  logic signed [TW_W-1:0] wi_i,
  input  logic                   inv_i,
  output logic signed [DW-1:0]   yr_o,
  output logic signed [DW-1:0]   yi_o
);

  localparam int PW = DW + TW_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND_C = SW'((RND_EN != 0) ? (1 << (TW_FRAC - 1)) : 0);
  localparam logic signed [SW-1:0] MAXV  = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MINV  = SW'(-(1 << (DW - 1)));

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAXV)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < MINV) return {1'b1, {(DW-1){1'b0}}};
    else               return v[DW-1:0];
  endfunction

  logic signed [TW_W-1:0] wi_e;
  logic signed [PW-1:0]   p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0]   sr, si;

  always_comb begin
    // -(-64) = +64 still fits the 8-bit twiddle range
    wi_e = inv_i ? -wi_i : wi_i;
    p_rr = PW'(xr_i) * PW'(wr_i);
    p_ii = PW'(xi_i) * PW'(wi_e);
    p_ri = PW'(xr_i) * PW'(wi_e);
    p_ir = PW'(xi_i) * PW'(wr_i);
    sr   = SW'(p_rr) - SW'(p_ii) + RND_C;
    si   = SW'(p_ri) + SW'(p_ir) + RND_C;
    yr_o = sat(sr >>> TW_FRAC);
    yi_o = sat(si >>> TW_FRAC);
  end

endmodule

// File: rtl/twiddlefactors_128.sv
// 64-entry twiddle ROM for a 128-point FFT: W_k = exp(-j*2*pi*k/128) in Q1.6, registered output.
module twiddlefactors_128
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic [TW_ADDR_W-1:0]   addr,
  output logic [2*TW_W-1:0]      tf_out
);

  // round(64*cos(pi*i/64)) for i = 32 down to 0; the quadrant symmetry rebuilds the rest.
  localparam logic [33*8-1:0] COS_TBL = {
    8'd0,  8'd3,  8'd6,  8'd9,  8'd12, 8'd16, 8'd19, 8'd22, 8'd24, 8'd27, 8'd30,
    8'd33, 8'd36, 8'd38, 8'd41, 8'd43, 8'd45, 8'd47, 8'd49, 8'd51, 8'd53, 8'd55,
    8'd56, 8'd58, 8'd59, 8'd60, 8'd61, 8'd62, 8'd63, 8'd63, 8'd64, 8'd64, 8'd64
  };

  function automatic logic signed [TW_W-1:0] cos_q6(input logic [5:0] i);
    return signed'(COS_TBL[{i, 3'b000} +: 8]);
  endfunction

  tw_t        w;
  logic [5:0] m;

  always_comb begin
    m = {1'b0, addr[4:0]};
    if (!addr[5]) begin
      w.re = cos_q6(m);
      w.im = -cos_q6(6'd32 - m);
    end else begin
      w.re = -cos_q6(6'd32 - m);
      w.im = -cos_q6(m);
    end
  end

  always_ff @(posedge clk) tf_out <= tw_pack(w);

endmodule

// File: rtl/twiddle_mult_seq.sv
// Twiddle multiply stage of the radix-2 DIT FFT: tags each lower-leg sample with (stage, j),
// fetches W from the registered ROM and emits x*W two cycles after acceptance.
module twiddle_mult_seq
  import fft_pkg::*;
#(
  parameter int DW     = 16,
  parameter int RND_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [2:0]           out_stage,
  output logic [5:0]           out_idx,
  output logic                 out_last
);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 inv;
    logic [2:0]           s;
    logic [5:0]           j;
    logic                 last;
  } stage_a_t;

  logic [2:0]           s_q, s_d;
  logic [5:0]           j_q, j_d;
  logic                 pipe_en, accept, last_cur;
  logic [TW_ADDR_W-1:0] k_cur, rom_addr, k_held_q;
  logic [2*TW_W-1:0]    tf_out;
  tw_t                  w;
  stage_a_t             a_q, a_d;
  logic [1:0]           vld_pipe_q;
  logic signed [DW-1:0] mul_re, mul_im;
  logic signed [DW-1:0] o_re_q, o_im_q;
  logic [2:0]           o_s_q;
  logic [5:0]           o_j_q;
  logic                 o_last_q;

  always_comb begin
    pipe_en  = !vld_pipe_q[1] || out_ready;
    in_ready = pipe_en && !clr;
    accept   = in_valid && in_ready;
    last_cur = (s_q == LAST_STAGE) && (j_q == J_LAST);
    k_cur    = tw_addr(s_q, j_q);
    // The ROM has no enable, so during a stall it re-reads the address of the held sample.
    rom_addr = pipe_en ? k_cur : k_held_q;

    s_d = s_q;
    j_d = j_q;
    if (clr) begin
      s_d = '0;
      j_d = '0;
    end else if (accept) begin
      j_d = j_q + 6'd1;
      if (j_q == J_LAST) s_d = last_cur ? 3'd0 : s_q + 3'd1;
    end

    a_d = a_q;
    if (accept) a_d = '{re: in_re, im: in_im, inv: in_inv, s: s_q, j: j_q, last: last_cur};
  end

  twiddlefactors_128 u_rom (
    .clk    (clk),
    .addr   (rom_addr),
    .tf_out (tf_out)
  );

  assign w = tw_unpack(tf_out);

  cmul_q6 #(.DW(DW), .RND_EN(RND_EN)) u_cmul (
    .xr_i  (a_q.re),
    .xi_i  (a_q.im),
    .wr_i  (w.re),
    .wi_i  (w.im),
    .inv_i (a_q.inv),
    .yr_o  (mul_re),
    .yi_o  (mul_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= '0;
      j_q        <= '0;
      k_held_q   <= '0;
      a_q        <= '0;
      vld_pipe_q <= '0;
      o_re_q     <= '0;
      o_im_q     <= '0;
      o_s_q      <= '0;
      o_j_q      <= '0;
      o_last_q   <= 1'b0;
    end else begin
      s_q      <= s_d;
      j_q      <= j_d;
      k_held_q <= rom_addr;
      a_q      <= a_d;
      if (clr)          vld_pipe_q <= '0;
      else if (pipe_en) vld_pipe_q <= {vld_pipe_q[0], accept};
      if (pipe_en && vld_pipe_q[0]) begin
        o_re_q   <= mul_re;
        o_im_q   <= mul_im;
        o_s_q    <= a_q.s;
        o_j_q    <= a_q.j;
        o_last_q <= a_q.last;
      end
    end
  end

  assign out_valid = vld_pipe_q[1];
  assign out_re    = o_re_q;
  assign out_im    = o_im_q;
  assign out_stage = o_s_q;
  assign out_idx   = o_j_q;
  assign out_last  = o_last_q;

endmodule

// File: tb/tb_twiddle_mult_seq.sv
// Bench for twiddle_mult_seq: trig-based reference model with a per-cycle monitor plus directed cases.
module tb_twiddle_mult_seq;

  localparam int  DW    = 16;
  localparam int  FRAME = 448;
  localparam real PI    = 3.14159265358979323846;

  typedef struct {
    int re;
    int im;
    int stage;
    int idx;
    bit last;
  } rec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clr = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 in_inv = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_re, out_im;
  logic [2:0]           out_stage;
  logic [5:0]           out_idx;
  logic                 out_last;

  bit   stall_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  rec_t exp_q[$];
  rec_t got_q[$];
  int   n_acc = 0;
  bit   prev_stall = 1'b0;
  rec_t held;

  twiddle_mult_seq #(.DW(DW), .RND_EN(1)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_stage(out_stage), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  // Stage s of a DIT FFT uses W_{2^(s+1)}^(j mod 2^s) = exp(-j*2*pi*(j mod 2^s)/2^(s+1)).
  function automatic rec_t exp_of(input int n, input int xr, input int xi, input bit inv);
    rec_t   r;
    int     p, s, j, m, wr, wi;
    real    a;
    longint yr, yi;
    p  = n % FRAME;
    s  = p / 64;
    j  = p % 64;
    m  = j % (1 << s);
    a  = -2.0 * PI * real'(m) / real'(1 << (s + 1));
    wr = rnd(64.0 * $cos(a));
    wi = rnd(64.0 * $sin(a));
    if (inv) wi = -wi;
    yr = longint'(xr) * wr - longint'(xi) * wi + 32;
    yi = longint'(xr) * wi + longint'(xi) * wr + 32;
    yr = yr >>> 6;
    yi = yi >>> 6;
    if (yr > 32767) yr = 32767; else if (yr < -32768) yr = -32768;
    if (yi > 32767) yi = 32767; else if (yi < -32768) yi = -32768;
    r.re = int'(yr); r.im = int'(yi); r.stage = s; r.idx = j; r.last = (p == FRAME - 1);
    return r;
  endfunction

  // Monitor: scoreboard against the model, stall stability, in_ready rule.
  always @(negedge clk) begin
    rec_t cur, e;
    cur = '{int'(out_re), int'(out_im), int'(out_stage), int'(out_idx), out_last};
    if (rst) begin
      exp_q.delete();
      n_acc = 0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, (!out_valid || out_ready) && !clr);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_re", cur.re, held.re);
        chk("stall_im", cur.im, held.im);
        chk("stall_stage", cur.stage, held.stage);
        chk("stall_idx", cur.idx, held.idx);
        chk("stall_last", cur.last, held.last);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(cur);
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_re", cur.re, e.re);
          chk("sb_im", cur.im, e.im);
          chk("sb_stage", cur.stage, e.stage);
          chk("sb_idx", cur.idx, e.idx);
          chk("sb_last", cur.last, e.last);
        end
      end
      prev_stall = out_valid && !out_ready && !clr;
      held = cur;
      if (clr) begin
        exp_q.delete();
        n_acc = 0;
      end else if (in_valid && in_ready) begin
        exp_q.push_back(exp_of(n_acc, int'(in_re), int'(in_im), in_inv));
        n_acc++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic send(input int re, input int im, input bit inv);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_re    = DW'(re);
    in_im    = DW'(im);
    in_inv   = inv;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      send(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 1'($urandom));
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    got_q.delete();
  endtask

  task automatic restart();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    drain();
  endtask

  task automatic get_out(input string nm, input int re, input int im, input int st, input int ix);
    rec_t r;
    for (int c = 0; c < 20 && got_q.size() == 0; c++) @(posedge clk);
    #1;
    if (got_q.size() == 0) chk({nm, "_timeout"}, 0, 1);
    else begin
      r = got_q.pop_front();
      chk({nm, "_re"}, r.re, re);
      chk({nm, "_im"}, r.im, im);
      chk({nm, "_stage"}, r.stage, st);
      chk({nm, "_idx"}, r.idx, ix);
    end
  endtask

  initial begin
    rec_t r;
    int   nlast, poslast;

    // Pin the model to hand-computed values.
    r = exp_of(400, 64, 0, 1'b0);         chk("pin_w16_re", r.re, 45); chk("pin_w16_im", r.im, -45);
    r = exp_of(400, 64, 0, 1'b1);         chk("pin_w16c_im", r.im, 45);
    r = exp_of(416, 32767, 32767, 1'b0);  chk("pin_w32_re", r.re, 32767); chk("pin_w32_im", r.im, -32767);
    r = exp_of(416, -32768, -32768, 1'b0); chk("pin_sat_re", r.re, -32768); chk("pin_sat_im", r.im, 32767);
    r = exp_of(447, 1, 1, 1'b0);          chk("pin_last", r.last, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_re", out_re, 0);
    chk("rst_im", out_im, 0);
    chk("rst_stage", out_stage, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(1000, -500, 1'b0);
    chk("lat_t1", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_t2", out_valid, 1);
    get_out("s0_ident", 1000, -500, 0, 0);

    restart(); fill(400); drain();
    send(64, 0, 1'b0);
    get_out("w16", 45, -45, 6, 16);

    restart(); fill(400); drain();
    send(64, 0, 1'b1);
    get_out("w16_conj", 45, 45, 6, 16);
    fill(15); drain();
    send(32767, 32767, 1'b0);
    get_out("w32_max", 32767, -32767, 6, 32);

    restart(); fill(416); drain();
    send(-32768, -32768, 1'b0);
    get_out("w32_sat", -32768, 32767, 6, 32);

    // One full frame back to back.
    restart();
    for (int i = 0; i < FRAME; i++)
      send(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("frame_count", got_q.size(), FRAME);
    nlast = 0; poslast = -1;
    for (int i = 0; i < FRAME && got_q.size() > 0; i++) begin
      r = got_q.pop_front();
      chk("frame_stage", r.stage, i / 64);
      chk("frame_idx", r.idx, i % 64);
      if (r.last) begin nlast++; poslast = i; end
    end
    chk("frame_last_cnt", nlast, 1);
    chk("frame_last_pos", poslast, FRAME - 1);
    send(5, 6, 1'b0);
    get_out("frame_wrap", 5, 6, 0, 0);

    // Random stalls and input gaps against the model.
    restart();
    stall_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 1'($urandom));
    end
    stall_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_drain_empty", exp_q.size(), 0);

    // clr at s=3, j=20 with stage A holding a sample.
    restart(); fill(212);
    clr = 1'b1; in_valid = 1'b1; in_re = 16'sd11; in_im = 16'sd22;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    got_q.delete();
    @(posedge clk);
    #1;
    chk("clr_stageA_flushed", out_valid, 0);
    send(100, 200, 1'b0);
    get_out("clr_next", 100, 200, 0, 0);

    // Asynchronous reset mid-frame.
    restart(); fill(212);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    send(7, -9, 1'b0);
    get_out("rst_next", 7, -9, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
